tc_burst_ram_pipe: RTL and testbench

//   Parametrised burst RAM: LANES consecutive words per access, read data returned through
//   a LATENCY-stage pipeline with a one-cycle ready strobe. Adds per-lane write mask,

---
 rtl/tc_burst_ram_pipe_if.sv | 43 ++++
 rtl/tc_burst_ram_pipe.sv | 147 ++++++++++++++
 tb/tb_tc_burst_ram_pipe.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tc_burst_ram_pipe_if.sv
// ----------------------------------------------------------------------------
// tc_burst_ram_pipe_if
//   Request/response bundle for the burst RAM. The master issues load/save/clear
//   requests for LANES consecutive words at a base address. The slave reports a
//   clear sweep in progress (busy) and returns read bursts (out) with a one-cycle
//   ready strobe.
//
//   Signals
//     load     master->slave  read LANES words starting at address
//     save     master->slave  write the lanes enabled in wmask
//     clear    master->slave  start a memory clear sweep
//     address  master->slave  base word address (ADDR_WIDTH bits)
//     wmask    master->slave  per-lane write enable; bit k gates lane k
//     in       master->slave  write data; lane k = in[k*WIDTH +: WIDTH]
//     busy     slave->master  clear sweep running, requests ignored
//     ready    slave->master  one-cycle strobe, out holds a completed read
//     out      slave->master  read data; lane k = in the same layout as in
// ----------------------------------------------------------------------------
interface tc_burst_ram_pipe_if #(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int LANES      = 4
);
    logic                     load;
    logic                     save;
    logic                     clear;
    logic [ADDR_WIDTH-1:0]    address;
    logic [LANES-1:0]         wmask;
    logic [LANES*WIDTH-1:0]   in;
    logic                     busy;
    logic                     ready;
    logic [LANES*WIDTH-1:0]   out;

    modport master (
        output load, save, clear, address, wmask, in,
        input  busy, ready, out
    );

    modport slave (
        input  load, save, clear, address, wmask, in,
        output busy, ready, out
    );
endinterface

// File: rtl/tc_burst_ram_pipe.sv
// ----------------------------------------------------------------------------
// tc_burst_ram_pipe
//   Burst RAM holding DEPTH words of WIDTH bits. Every access covers LANES
//   consecutive words starting at (address mod DEPTH), wrapping past the top of
//   the array. Reads travel down a LATENCY-stage pipeline and pop out with a
//   one-cycle ready strobe; idle cycles carry zero data so out is 0 whenever
//   ready is 0. Writes honour a per-lane mask. After reset, and whenever clear
//   is accepted, a sequencer zeroes one word per cycle for DEPTH cycles while
//   busy is high; requests arriving during the sweep are dropped, reads already
//   in the pipeline still drain.
//
//   Ports
//     clk    in   rising-edge clock
//     rst_n  in   asynchronous active-low reset (restarts the clear sweep)
//     bus    slave modport of tc_burst_ram_pipe_if
//              load/save/clear/address/wmask/in  requests
//              busy/ready/out                    status and read data
// ----------------------------------------------------------------------------
module tc_burst_ram_pipe #(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = 16,
    parameter int LANES      = 4,
    parameter int LATENCY    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    tc_burst_ram_pipe_if.slave   bus
);

    localparam int DW = LANES * WIDTH;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Modulo arithmetic is done one bit wider than needed so DEPTH itself is
    // always representable as the divisor.
    localparam int CW = (ADDR_WIDTH > IW) ? ADDR_WIDTH : IW + 1;
    localparam logic [IW-1:0] IDX_MASK = IW'(DEPTH - 1);

    typedef enum logic {
        S_CLEAR,
        S_IDLE
    } state_t;

    state_t           state;
    logic [IW-1:0]    clr_ptr;
    logic             busy_r;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [IW-1:0]    base;
    logic [IW-1:0]    lane_idx [LANES];
    logic [DW-1:0]    rd_word;
    logic             ld_ok;
    logic             sv_ok;

    logic [DW-1:0]    data_p [LATENCY];
    logic [LATENCY-1:0] vld_p;

    // Lane addressing: upper address bits fall away in the modulo, and the
    // lane offset wraps within the power-of-two array.
    always_comb begin
        base = IW'(CW'(bus.address) % CW'(DEPTH));
        for (int k = 0; k < LANES; k++) begin
            lane_idx[k] = (base + IW'(k)) & IDX_MASK;
        end
    end

    always_comb begin
        rd_word = '0;
        for (int k = 0; k < LANES; k++) begin
            rd_word[k*WIDTH +: WIDTH] = mem[lane_idx[k]];
        end
    end

    assign ld_ok = bus.load & ~busy_r;
    assign sv_ok = bus.save & ~busy_r;

    // Clear sequencer. busy is registered alongside the state so it is high
    // for exactly DEPTH cycles per sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_CLEAR;
            clr_ptr <= '0;
            busy_r  <= 1'b1;
        end else begin
            case (state)
                S_CLEAR: begin
                    if (clr_ptr == IDX_MASK) begin
                        state   <= S_IDLE;
                        busy_r  <= 1'b0;
                        clr_ptr <= '0;
                    end else begin
                        clr_ptr <= clr_ptr + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (bus.clear) begin
                        state   <= S_CLEAR;
                        busy_r  <= 1'b1;
                        clr_ptr <= '0;
                    end
                end
                default: begin
                    state   <= S_CLEAR;
                    busy_r  <= 1'b1;
                    clr_ptr <= '0;
                end
            endcase
        end
    end

    // Storage is deliberately not reset; the sweep that follows reset zeroes
    // it. Lane indices of one burst are distinct because DEPTH >= LANES.
    always_ff @(posedge clk) begin
        if (busy_r) begin
            mem[clr_ptr] <= '0;
        end else if (sv_ok) begin
            for (int k = 0; k < LANES; k++) begin
                if (bus.wmask[k]) begin
                    mem[lane_idx[k]] <= bus.in[k*WIDTH +: WIDTH];
                end
            end
        end
    end

    // ---- stage p0: capture the burst (pre-write contents) on an accepted load
    // ---- stages p1..p(LATENCY-1): plain delay line, last stage drives out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LATENCY; i++) begin
                data_p[i] <= '0;
            end
            vld_p <= '0;
        end else begin
            data_p[0] <= ld_ok ? rd_word : '0;
            vld_p[0]  <= ld_ok;
            for (int i = 1; i < LATENCY; i++) begin
                data_p[i] <= data_p[i-1];
                vld_p[i]  <= vld_p[i-1];
            end
        end
    end

    assign bus.busy  = busy_r;
    assign bus.ready = vld_p[LATENCY-1];
    assign bus.out   = data_p[LATENCY-1];

endmodule

// File: tb/tb_tc_burst_ram_pipe.sv
// ----------------------------------------------------------------------------
// tb_tc_burst_ram_pipe
//   Directed and randomized stimulus for tc_burst_ram_pipe, checked every cycle
//   against a word-array reference model with a countdown for busy and a queue
//   of scheduled read results.
// ----------------------------------------------------------------------------
module tb_tc_burst_ram_pipe;

    localparam int WIDTH      = 16;
    localparam int DEPTH      = 256;
    localparam int ADDR_WIDTH = 16;
    localparam int LANES      = 4;
    localparam int LATENCY    = 2;
    localparam int DW         = LANES * WIDTH;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    tc_burst_ram_pipe_if #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .LANES(LANES)) bus ();

    tc_burst_ram_pipe #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH),
        .LANES(LANES), .LATENCY(LATENCY)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference model state
    logic [WIDTH-1:0] mm [DEPTH];
    int               busy_left;
    int               cyc;
    int               due_q [$];
    logic [DW-1:0]    dat_q [$];
    logic             exp_busy;
    logic             exp_ready;
    logic [DW-1:0]    exp_out;

    // Bookkeeping
    int               n_pass;
    int               n_fail;
    int               n_total;
    int               rdy_seen;
    int               busy_cyc;
    logic [DW-1:0]    last_rd;

    function automatic logic [DW-1:0] pack4(int l3, int l2, int l1, int l0);
        return {WIDTH'(l3), WIDTH'(l2), WIDTH'(l1), WIDTH'(l0)};
    endfunction

    // Reset empties the read pipe; the sweep that follows always zeroes
    // every word before any request can be accepted.
    function automatic void model_reset();
        busy_left = DEPTH;
        due_q.delete();
        dat_q.delete();
        exp_busy  = 1'b1;
        exp_ready = 1'b0;
        exp_out   = '0;
        for (int i = 0; i < DEPTH; i++) mm[i] = '0;
    endfunction

    function automatic void model_edge();
        logic [DW-1:0] rd;
        int            b;
        rd        = '0;
        exp_ready = 1'b0;
        exp_out   = '0;
        if (busy_left == 0) begin
            b = int'(bus.address) % DEPTH;
            if (bus.load) begin
                for (int k = 0; k < LANES; k++) rd[k*WIDTH +: WIDTH] = mm[(b + k) % DEPTH];
                due_q.push_back(cyc + LATENCY - 1);
                dat_q.push_back(rd);
            end
            if (bus.save) begin
                for (int k = 0; k < LANES; k++)
                    if (bus.wmask[k]) mm[(b + k) % DEPTH] = bus.in[k*WIDTH +: WIDTH];
            end
            if (bus.clear) begin
                busy_left = DEPTH;
                for (int i = 0; i < DEPTH; i++) mm[i] = '0;
            end
        end else begin
            busy_left--;
        end
        if (due_q.size() > 0 && due_q[0] == cyc) begin
            exp_ready = 1'b1;
            exp_out   = dat_q.pop_front();
            void'(due_q.pop_front());
        end
        exp_busy = (busy_left != 0);
    endfunction

    task automatic chk(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(logic ld, logic sv, logic cl, logic [ADDR_WIDTH-1:0] a,
                         logic [LANES-1:0] wm, logic [DW-1:0] d);
        bus.load    = ld;
        bus.save    = sv;
        bus.clear   = cl;
        bus.address = a;
        bus.wmask   = wm;
        bus.in      = d;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        if (rst_n) model_edge();
        #1;
        chk("busy",  DW'(bus.busy),  DW'(exp_busy));
        chk("ready", DW'(bus.ready), DW'(exp_ready));
        chk("out",   bus.out,        exp_out);
        if (bus.ready) begin
            last_rd = bus.out;
            rdy_seen++;
        end
    endtask

    task automatic read_burst(string tag, logic [ADDR_WIDTH-1:0] a, logic [DW-1:0] want);
        last_rd = 'x;
        drive(1'b1, 1'b0, 1'b0, a, '0, '0);
        step();
        idle();
        repeat (LATENCY) step();
        chk(tag, last_rd, want);
    endtask

    task automatic count_sweep(string tag);
        busy_cyc = bus.busy ? 1 : 0;
        for (int i = 0; i < DEPTH + 4; i++) begin
            step();
            if (bus.busy) busy_cyc++;
        end
        chk(tag, DW'(busy_cyc), DW'(DEPTH));
    endtask

    initial begin
        logic [ADDR_WIDTH-1:0] a;
        int                    sel;
        n_pass = 0; n_fail = 0; n_total = 0; cyc = 0; rdy_seen = 0;
        last_rd = '0;
        idle();
        model_reset();

        // Reset state held over a few edges
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        count_sweep("busy_len_reset");

        // Freshly swept memory reads as zero
        read_burst("rd_10_zero", 16'h0010, '0);

        // Full-mask write then read back
        drive(1'b0, 1'b1, 1'b0, 16'h0020, 4'hF, pack4(4, 3, 2, 1));
        step();
        read_burst("rd_20", 16'h0020, pack4(4, 3, 2, 1));

        // Burst wrapping past the top of the array, upper address bits ignored
        drive(1'b0, 1'b1, 1'b0, 16'h00FE, 4'hF, pack4(16'hD, 16'hC, 16'hB, 16'hA));
        step();
        read_burst("rd_wrap", 16'h01FE, pack4(16'hD, 16'hC, 16'hB, 16'hA));
        read_burst("rd_low", 16'hFF00, pack4(0, 0, 16'hD, 16'hC));

        // Same-edge load+save returns old data; masked lanes keep old values
        last_rd = 'x;
        drive(1'b1, 1'b1, 1'b0, 16'h0020, 4'b0101, pack4(8, 7, 6, 5));
        step();
        idle();
        repeat (LATENCY) step();
        chk("rw_old", last_rd, pack4(4, 3, 2, 1));
        read_burst("rd_masked", 16'h0020, pack4(4, 7, 2, 5));

        // Back-to-back loads give back-to-back ready pulses
        rdy_seen = 0;
        drive(1'b1, 1'b0, 1'b0, 16'h0020, '0, '0); step();
        drive(1'b1, 1'b0, 1'b0, 16'h00FE, '0, '0); step();
        drive(1'b1, 1'b0, 1'b0, 16'h0010, '0, '0); step();
        idle();
        repeat (LATENCY + 1) step();
        chk("burst3", DW'(rdy_seen), DW'(3));

        // clear accepted; requests during the sweep are dropped
        drive(1'b0, 1'b0, 1'b1, '0, '0, '0);
        step();
        rdy_seen = 0;
        drive(1'b1, 1'b0, 1'b0, 16'h0020, '0, '0); repeat (4) step();
        drive(1'b0, 1'b1, 1'b0, 16'h0030, 4'hF, pack4(9, 9, 9, 9)); step();
        drive(1'b0, 1'b0, 1'b1, 16'h0030, '0, '0); step();
        idle();
        repeat (LATENCY) step();
        chk("busy_drop", DW'(rdy_seen), DW'(0));
        for (int i = 0; i < DEPTH + 2 && bus.busy; i++) step();
        chk("sweep_done", DW'(bus.busy), DW'(0));
        read_burst("rd_30_cleared", 16'h0030, '0);
        read_burst("rd_20_cleared", 16'h0020, '0);

        // Randomized traffic concentrated on a few addresses and the wrap point
        for (int i = 0; i < 1200; i++) begin
            sel = $urandom_range(0, 3);
            if (sel == 0)      a = 16'($urandom);
            else if (sel == 1) a = {8'($urandom), 8'(8'hFC + $urandom_range(0, 3))};
            else               a = {8'($urandom), 8'($urandom_range(0, 15))};
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 499) == 0), a,
                  LANES'($urandom), {32'($urandom), 32'($urandom)});
            step();
        end
        idle();
        for (int i = 0; i < DEPTH + 2 && bus.busy; i++) step();
        chk("idle_before_clear", DW'(bus.busy), DW'(0));

        // clear alongside traffic, then reset partway through the sweep
        drive(1'b1, 1'b1, 1'b1, 16'h0040, 4'hF, {32'($urandom), 32'($urandom)});
        step();
        for (int i = 0; i < 99; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0,
                  16'($urandom), LANES'($urandom), {32'($urandom), 32'($urandom)});
            step();
        end
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_busy",  DW'(bus.busy),  DW'(1));
        chk("async_ready", DW'(bus.ready), DW'(0));
        chk("async_out",   bus.out,        '0);
        idle();
        repeat (2) step();
        rst_n = 1'b1;
        count_sweep("busy_len_restart");
        for (int j = 0; j < 6; j++) begin
            read_burst("rd_after_restart", 16'($urandom), '0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
